// File: rtl/pad_mask_gen.sv
// Padding mask generator: turns a raster walk of output columns into per-member
// pass masks plus horizontal/vertical pad codes for a KWxKH kernel.
module pad_mask_gen #(
    parameter int MEMBERS   = 24,
    parameter int KW_MAX    = 7,
    parameter int KH_MAX    = 7,
    parameter int BITS_COLS = 10,
    parameter int BITS_ROWS = 10,
    localparam int BITS_KW2 = $clog2(KW_MAX / 2 + 1),
    localparam int BITS_KH2 = $clog2(KH_MAX / 2 + 1),
    localparam int BITS_KW  = $clog2(KW_MAX + 1),
    localparam int BITS_KH  = $clog2(KH_MAX + 1)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 aclken,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_config,
    input  logic                 s_cin_last,
    input  logic [BITS_KW2-1:0]  cfg_kw2,
    input  logic [BITS_KH2-1:0]  cfg_kh2,
    input  logic [BITS_COLS-1:0] cfg_cols_1,
    input  logic [BITS_ROWS-1:0] cfg_rows_1,
    input  logic                 cfg_same,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [MEMBERS-1:0]   mask_full,
    output logic [BITS_KW-1:0]   clr_col,
    output logic [BITS_KH-1:0]   clr_row,
    output logic                 m_last_col,
    output logic                 m_last_frame,
    output logic                 cfg_err
);

    localparam int CW   = BITS_COLS + 2;
    localparam int RW   = BITS_ROWS + 2;
    localparam int KTBL = 1 << BITS_KW2;

    // Ones at the last member of every complete kernel-width group.
    function automatic logic [MEMBERS-1:0] mod_pattern(input int unsigned k2);
        logic [MEMBERS-1:0] p;
        int unsigned        kw;
        kw = 2 * k2 + 1;
        p  = '0;
        for (int unsigned m = 0; m < MEMBERS; m++)
            p[m] = ((m % kw) == kw - 1) && (m < (MEMBERS / kw) * kw);
        return p;
    endfunction

    logic [MEMBERS-1:0] mask_tbl [KTBL];

    for (genvar k = 0; k < KTBL; k++) begin : g_tbl
        assign mask_tbl[k] = mod_pattern(k);
    end

    logic [BITS_KW2-1:0]  kw2_q, kw2_d;
    logic [BITS_KH2-1:0]  kh2_q, kh2_d;
    logic [BITS_COLS-1:0] cols_1_q, cols_1_d, col_q, col_d;
    logic [BITS_ROWS-1:0] rows_1_q, rows_1_d, row_q, row_d;
    logic                 same_q, same_d;
    logic                 err_q, err_d;
    logic                 m_valid_q, m_valid_d;
    logic [MEMBERS-1:0]   mask_q, mask_d;
    logic [BITS_KW-1:0]   clr_col_q, clr_col_d;
    logic [BITS_KH-1:0]   clr_row_q, clr_row_d;
    logic                 last_col_q, last_col_d;
    logic                 last_frame_q, last_frame_d;

    logic          acc;
    logic [CW-1:0] c_x, kw2_x, hi_c, code_c;
    logic [RW-1:0] r_x, kh2_x, hi_r, code_r;
    logic          border_c, border_r, at_last_c, at_last_r;

    assign s_ready = !m_valid_q || m_ready;
    assign acc     = aclken && s_valid && s_ready;

    always_comb begin
        c_x   = CW'(col_q);
        kw2_x = CW'(kw2_q);
        hi_c  = CW'(cols_1_q) - kw2_x;
        r_x   = RW'(row_q);
        kh2_x = RW'(kh2_q);
        hi_r  = RW'(rows_1_q) - kh2_x;

        border_c = (c_x < kw2_x) || (c_x > hi_c);
        border_r = (r_x < kh2_x) || (r_x > hi_r);
        at_last_c = (col_q == cols_1_q);
        at_last_r = (row_q == rows_1_q);

        code_c = '0;
        if (c_x < kw2_x)
            code_c = ((kw2_x - c_x) << 1) - CW'(1);
        else if (c_x > hi_c)
            code_c = (c_x - hi_c) << 1;

        code_r = '0;
        if (r_x < kh2_x)
            code_r = ((kh2_x - r_x) << 1) - RW'(1);
        else if (r_x > hi_r)
            code_r = (r_x - hi_r) << 1;
    end

    always_comb begin
        kw2_d        = kw2_q;
        kh2_d        = kh2_q;
        cols_1_d     = cols_1_q;
        rows_1_d     = rows_1_q;
        same_d       = same_q;
        err_d        = err_q;
        col_d        = col_q;
        row_d        = row_q;
        m_valid_d    = m_valid_q;
        mask_d       = mask_q;
        clr_col_d    = clr_col_q;
        clr_row_d    = clr_row_q;
        last_col_d   = last_col_q;
        last_frame_d = last_frame_q;

        if (acc) begin
            m_valid_d = 1'b1;
            if (s_config) begin
                kw2_d        = cfg_kw2;
                kh2_d        = cfg_kh2;
                cols_1_d     = cfg_cols_1;
                rows_1_d     = cfg_rows_1;
                same_d       = cfg_same;
                err_d        = (CW'(cfg_cols_1) < (CW'(cfg_kw2) << 1)) ||
                               (RW'(cfg_rows_1) < (RW'(cfg_kh2) << 1));
                col_d        = '0;
                row_d        = '0;
                mask_d       = '1;
                clr_col_d    = '0;
                clr_row_d    = '0;
                last_col_d   = 1'b0;
                last_frame_d = 1'b0;
            end else begin
                last_col_d   = at_last_c;
                last_frame_d = at_last_c && at_last_r;
                if (same_q) begin
                    clr_col_d = code_c[BITS_KW-1:0];
                    clr_row_d = code_r[BITS_KH-1:0];
                end else begin
                    clr_col_d = '0;
                    clr_row_d = '0;
                end
                if (err_q || (!same_q && (border_c || border_r)))
                    mask_d = '0;
                else
                    mask_d = mask_tbl[kw2_q];
                if (s_cin_last) begin
                    if (at_last_c) begin
                        col_d = '0;
                        row_d = at_last_r ? '0 : row_q + BITS_ROWS'(1);
                    end else begin
                        col_d = col_q + BITS_COLS'(1);
                    end
                end
            end
        end else if (aclken && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            kw2_q        <= '0;
            kh2_q        <= '0;
            cols_1_q     <= '0;
            rows_1_q     <= '0;
            same_q       <= 1'b1;
            err_q        <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            m_valid_q    <= 1'b0;
            mask_q       <= '0;
            clr_col_q    <= '0;
            clr_row_q    <= '0;
            last_col_q   <= 1'b0;
            last_frame_q <= 1'b0;
        end else begin
            kw2_q        <= kw2_d;
            kh2_q        <= kh2_d;
            cols_1_q     <= cols_1_d;
            rows_1_q     <= rows_1_d;
            same_q       <= same_d;
            err_q        <= err_d;
            col_q        <= col_d;
            row_q        <= row_d;
            m_valid_q    <= m_valid_d;
            mask_q       <= mask_d;
            clr_col_q    <= clr_col_d;
            clr_row_q    <= clr_row_d;
            last_col_q   <= last_col_d;
            last_frame_q <= last_frame_d;
        end
    end

    assign m_valid      = m_valid_q;
    assign mask_full    = mask_q;
    assign clr_col      = clr_col_q;
    assign clr_row      = clr_row_q;
    assign m_last_col   = last_col_q;
    assign m_last_frame = last_frame_q;
    assign cfg_err      = err_q;

endmodule

// File: tb/tb_pad_mask_gen.sv
// Directed self-checking bench for pad_mask_gen with default parameters.
module tb_pad_mask_gen;

    logic        aclk = 1'b0;
    logic        areset;
    logic        aclken;
    logic        s_valid;
    logic        s_ready;
    logic        s_config;
    logic        s_cin_last;
    logic [1:0]  cfg_kw2;
    logic [1:0]  cfg_kh2;
    logic [9:0]  cfg_cols_1;
    logic [9:0]  cfg_rows_1;
    logic        cfg_same;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] mask_full;
    logic [2:0]  clr_col;
    logic [2:0]  clr_row;
    logic        m_last_col;
    logic        m_last_frame;
    logic        cfg_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [23:0] ONES  = 24'hFFFFFF;
    localparam logic [23:0] PAT5  = 24'h084210;   // bits 4,9,14,19

    logic [2:0] col_exp [8] = '{3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd4};
    logic [2:0] row_exp [4] = '{3'd1, 3'd0, 3'd0, 3'd2};

    always #5 aclk = ~aclk;

    pad_mask_gen dut (
        .aclk         (aclk),
        .areset       (areset),
        .aclken       (aclken),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_config     (s_config),
        .s_cin_last   (s_cin_last),
        .cfg_kw2      (cfg_kw2),
        .cfg_kh2      (cfg_kh2),
        .cfg_cols_1   (cfg_cols_1),
        .cfg_rows_1   (cfg_rows_1),
        .cfg_same     (cfg_same),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .mask_full    (mask_full),
        .clr_col      (clr_col),
        .clr_row      (clr_row),
        .m_last_col   (m_last_col),
        .m_last_frame (m_last_frame),
        .cfg_err      (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic cfg, input logic last);
        s_config   = cfg;
        s_cin_last = last;
        s_valid    = 1'b1;
        @(posedge aclk);
        #1;
        s_valid  = 1'b0;
        s_config = 1'b0;
    endtask

    task automatic configure(input int kw2, input int kh2, input int cols_1,
                             input int rows_1, input logic same);
        cfg_kw2    = 2'(kw2);
        cfg_kh2    = 2'(kh2);
        cfg_cols_1 = 10'(cols_1);
        cfg_rows_1 = 10'(rows_1);
        cfg_same   = same;
        send(1'b1, 1'b0);
    endtask

    initial begin
        int c;
        int r;
        areset     = 1'b1;
        aclken     = 1'b1;
        s_valid    = 1'b0;
        s_config   = 1'b0;
        s_cin_last = 1'b0;
        cfg_kw2    = '0;
        cfg_kh2    = '0;
        cfg_cols_1 = '0;
        cfg_rows_1 = '0;
        cfg_same   = 1'b0;
        m_ready    = 1'b1;

        #12;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_mask", 32'(mask_full), 0);
        chk("rst_clr_col", 32'(clr_col), 0);
        chk("rst_clr_row", 32'(clr_row), 0);
        chk("rst_last", 32'({m_last_col, m_last_frame}), 0);
        chk("rst_err", 32'(cfg_err), 0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 1);

        // data beat before any config uses the reset config
        send(1'b0, 1'b1);
        chk("pre_valid", 32'(m_valid), 1);
        chk("pre_mask", 32'(mask_full), 32'(ONES));
        chk("pre_codes", 32'({clr_col, clr_row}), 0);
        chk("pre_last", 32'({m_last_col, m_last_frame}), 32'b11);

        configure(2, 1, 7, 3, 1'b1);
        chk("cfg_mask", 32'(mask_full), 32'(ONES));
        chk("cfg_codes", 32'({clr_col, clr_row}), 0);
        chk("cfg_last", 32'({m_last_col, m_last_frame}), 0);
        chk("cfg_err_ok", 32'(cfg_err), 0);

        for (int i = 0; i < 32; i++) begin
            c = i % 8;
            r = i / 8;
            send(1'b0, 1'b1);
            chk("same_clr_col", 32'(clr_col), 32'(col_exp[c]));
            chk("same_clr_row", 32'(clr_row), 32'(row_exp[r]));
            chk("same_mask", 32'(mask_full), 32'(PAT5));
            chk("same_last_col", 32'(m_last_col), 32'(c == 7));
            chk("same_last_frame", 32'(m_last_frame), 32'(i == 31));
        end

        configure(2, 1, 7, 3, 1'b0);
        for (int i = 0; i < 32; i++) begin
            c = i % 8;
            r = i / 8;
            send(1'b0, 1'b1);
            chk("valid_mask", 32'(mask_full),
                (c >= 2 && c <= 5 && r >= 1 && r <= 2) ? 32'(PAT5) : 32'd0);
            chk("valid_codes", 32'({clr_col, clr_row}), 0);
        end

        // counters advance only on cin_last
        configure(2, 1, 7, 3, 1'b1);
        send(1'b0, 1'b0);
        chk("hold_c0a", 32'(clr_col), 3);
        send(1'b0, 1'b1);
        chk("hold_c0b", 32'(clr_col), 3);
        send(1'b0, 1'b1);
        chk("hold_c1", 32'(clr_col), 1);

        // stall with output holding c=6
        for (int i = 2; i <= 6; i++) send(1'b0, 1'b1);
        chk("pre_stall", 32'(clr_col), 2);
        m_ready    = 1'b0;
        s_valid    = 1'b1;
        s_cin_last = 1'b1;
        #1;
        chk("stall_s_ready", 32'(s_ready), 0);
        repeat (5) begin
            @(posedge aclk);
            #1;
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_clr_col", 32'(clr_col), 2);
            chk("stall_last_col", 32'(m_last_col), 0);
            chk("stall_s_ready", 32'(s_ready), 0);
        end
        m_ready = 1'b1;
        @(posedge aclk);
        #1;
        chk("release_clr_col", 32'(clr_col), 4);
        chk("release_last_col", 32'(m_last_col), 1);
        @(posedge aclk);
        #1;
        chk("next_row_col", 32'(clr_col), 3);
        chk("next_row_row", 32'(clr_row), 0);
        s_valid = 1'b0;
        @(posedge aclk);
        #1;
        chk("drain_valid", 32'(m_valid), 0);

        // clock enable low freezes everything
        aclken  = 1'b0;
        s_valid = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("clken_valid", 32'(m_valid), 0);
        aclken = 1'b1;
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        chk("clken_resume", 32'(clr_col), 1);

        // illegal geometry: cols_1=3 < 2*kw2=4
        configure(2, 0, 3, 0, 1'b1);
        chk("err_set", 32'(cfg_err), 1);
        send(1'b0, 1'b1);
        chk("err_mask", 32'(mask_full), 0);
        chk("err_hold", 32'(cfg_err), 1);
        configure(2, 0, 4, 0, 1'b1);
        chk("err_clear", 32'(cfg_err), 0);
        send(1'b0, 1'b1);
        chk("edge_cfg_mask", 32'(mask_full), 32'(PAT5));
        chk("edge_cfg_col", 32'(clr_col), 3);

        // reset mid-frame
        configure(2, 1, 7, 3, 1'b1);
        for (int i = 0; i < 9; i++) send(1'b0, 1'b1);
        chk("mid_clr_col", 32'(clr_col), 3);
        areset = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(m_valid), 0);
        chk("mid_rst_mask", 32'(mask_full), 0);
        chk("mid_rst_codes", 32'({clr_col, clr_row}), 0);
        @(negedge aclk);
        areset = 1'b0;
        send(1'b0, 1'b1);
        chk("post_rst_mask", 32'(mask_full), 32'(ONES));
        chk("post_rst_codes", 32'({clr_col, clr_row}), 0);
        chk("post_rst_last", 32'({m_last_col, m_last_frame}), 32'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
